instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Consumer-side controller for the program counter.
- Takes the current PC, issues a handshaked read to instruction memory, and buffers the returned instruction for decode.
- Drives PCWrite back to the program counter, so the PC advances only when decode has accepted an instruction or a redirect (flush) occurs.
- Sits between the program counter, the instruction memory port and the decode stage.

Parameters:
- PC_WIDTH, 32, width of PC and memory address.
- INSTR_WIDTH, 32, width of an instruction word.
- RESET_PC, 32'hFFFFFFFC, PC value present after reset. The fetch unit never requests this address.

Ports:
- CPU_clk  input  1  clock, rising edge.
- CPU_rst_n  input  1  reset; asynchronous, active-low.
- PC  input  PC_WIDTH  current PC from the program counter.
- PCWrite  output  1  PC update enable to the program counter (PC loads PC_Next on the next edge).
- flush  input  1  redirect request. PC_Next carries the target this cycle.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  PC_WIDTH  request address (= PC).
- imem_rsp_valid  input  1  read data valid, 1-cycle pulse per accepted request.
- imem_rsp_data  input  INSTR_WIDTH  read data.
- Instr_valid  output  1  buffered instruction valid.
- Instr  output  INSTR_WIDTH  buffered instruction.
- Instr_PC  output  PC_WIDTH  address of the buffered instruction.
- decode_ready  input  1  decode consumes Instr this cycle.
- fetch_fault  output  1  misaligned PC detected; sticky.

Behaviour:
- Reset (async): state=BOOT. All outputs are 0 except PCWrite=1 combinationally in BOOT.
- BOOT: PCWrite=1 for exactly one cycle, so the PC leaves RESET_PC, then go to REQ. No memory request is issued.
- REQ:
  - If PC[1:0]!=0: no request, go to FAULT.
  - Otherwise imem_req_valid=1 and imem_req_addr=PC.
  - On imem_req_ready: latch PC into Instr_PC, go to WAIT.
  - PCWrite=0 unless flush.
- WAIT:
  - On imem_rsp_valid: Instr<=imem_rsp_data, Instr_valid<=1 next cycle, go to HOLD.
  - A response before acceptance is ignored.
- HOLD:
  - Instr_valid=1; Instr and Instr_PC stay stable.
  - On decode_ready: PCWrite=1, Instr_valid<=0, go to REQ.
- DROP: an outstanding response is discarded. On imem_rsp_valid, go to REQ. Instr_valid=0.
- FAULT: fetch_fault=1, no requests. Leave only on flush (go to REQ) or reset.
- Flush handling: in every state except BOOT, flush forces PCWrite=1 and Instr_valid<=0 next cycle.
  - REQ with the handshake in the same cycle: go to DROP.
  - REQ without the handshake: stay in REQ. imem_req_valid may be retracted only in this case.
  - WAIT without rsp_valid: go to DROP.
  - WAIT with rsp_valid in the same cycle: discard data, go to REQ.
  - HOLD: go to REQ. decode_ready is ignored that cycle.
  - FAULT: clear fault, go to REQ.
- Latency: from REQ handshake at edge N, minimum Instr_valid=1 at N+2 with rsp_valid at N+1. Best-case throughput is 1 instruction per 3 cycles.
- At most one outstanding request. imem_req_valid=0 in WAIT, HOLD, DROP, FAULT and BOOT.
- PCWrite is combinational from state, flush and decode_ready. It is asserted at most once per consumed instruction plus once per flush.
- Reset mid-transaction returns to BOOT. Memory must drop any pending response on reset.

Decomposition:
- Shared package:
  - state encoding localparams: BOOT, REQ, WAIT, HOLD, DROP, FAULT.
  - RESET_PC constant, shared with the program counter.
  - INSTR_WIDTH and PC_WIDTH defaults.
- Single module. The instruction/PC holding register is inline; no sub-module is needed.

Test Plan:
- Reset release with memory always ready, 1-cycle response, decode_ready=1, and PC model seeded 0xFFFFFFFC: PCWrite=1 in the first cycle, first request addr 0x0, Instr_valid with Instr_PC=0x0 three cycles after BOOT, then 0x4, 0x8 in order.
- imem_req_ready low for 4 cycles at PC=0x10: imem_req_valid and addr stay 0x10 and PCWrite=0 throughout; the handshake occurs on the 5th cycle.
- decode_ready=0 for 5 cycles in HOLD: Instr, Instr_PC and Instr_valid stay stable and PCWrite=0; PC advances one step after decode_ready=1.
- flush in WAIT for request 0x20 with target 0x100: the response for 0x20 is dropped (Instr_valid never shows 0x20), and the next request addr is 0x100.
- flush together with rsp_valid in WAIT, and flush in HOLD: no stale instruction is presented, and PCWrite=1 exactly once per flush.
- PC=0x102 at REQ: no request, fetch_fault=1 sticky; a flush to 0x200 clears the fault, and the next request addr is 0x200.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch-unit constants, state encoding and helpers
package instr_fetch_unit_pkg;

    localparam int PC_WIDTH_DEF    = 32;
    localparam int INSTR_WIDTH_DEF = 32;

    // Also loaded by the program counter on reset; the fetch unit never requests it.
    localparam logic [31:0] RESET_PC_DEF = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DROP  = 3'd4,
        FAULT = 3'd5
    } fetch_state_t;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/response port
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [PC_WIDTH-1:0]    imem_req_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch controller: PC-driven imem read, single instruction buffer, PCWrite back-pressure
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEF)
)(
    input  logic                   CPU_clk,
    input  logic                   CPU_rst_n,
    input  logic [PC_WIDTH-1:0]    PC,
    output logic                   PCWrite,
    input  logic                   flush,
    instr_fetch_unit_if.master     bus,
    output logic                   Instr_valid,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [PC_WIDTH-1:0]    Instr_PC,
    input  logic                   decode_ready,
    output logic                   fetch_fault
);

    fetch_state_t state;
    logic         pc_ok;
    logic         req_fire;

    assign pc_ok = !pc_misaligned(PC[1:0]);

    // Holding off at RESET_PC keeps the reset vector from ever reaching memory.
    assign bus.imem_req_valid = (state == REQ) && pc_ok && (PC != RESET_PC);
    assign bus.imem_req_addr  = (state == REQ) ? PC : '0;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign PCWrite     = (state == BOOT)
                      || (flush && (state != BOOT))
                      || ((state == HOLD) && decode_ready);
    assign fetch_fault = (state == FAULT);

    always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n) begin
            state       <= BOOT;
            Instr_valid <= 1'b0;
            Instr       <= '0;
            Instr_PC    <= '0;
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (!pc_ok) begin
                        state <= flush ? REQ : FAULT;
                    end else if (req_fire) begin
                        Instr_PC <= PC;
                        state    <= flush ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (flush) begin
                            state <= REQ;
                        end else begin
                            Instr       <= bus.imem_rsp_data;
                            Instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                HOLD: begin
                    // A flush wins over decode_ready: the buffered word is stale.
                    if (flush || decode_ready) begin
                        Instr_valid <= 1'b0;
                        state       <= REQ;
                    end
                end
                DROP: begin
                    if (bus.imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                FAULT: begin
                    if (flush) begin
                        state <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized bench for instr_fetch_unit with PC and memory models
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        CPU_clk = 1'b0;
    logic        CPU_rst_n;
    logic [31:0] PC;
    logic        PCWrite;
    logic        flush;
    logic        Instr_valid;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        decode_ready;
    logic        fetch_fault;

    always #5 CPU_clk = ~CPU_clk;

    instr_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    instr_fetch_unit dut (
        .CPU_clk      (CPU_clk),
        .CPU_rst_n    (CPU_rst_n),
        .PC           (PC),
        .PCWrite      (PCWrite),
        .flush        (flush),
        .bus          (bus),
        .Instr_valid  (Instr_valid),
        .Instr        (Instr),
        .Instr_PC     (Instr_PC),
        .decode_ready (decode_ready),
        .fetch_fault  (fetch_fault)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] pc_m, exp_addr, paddr;
    bit          pend, boot;
    int          cnt, rsp_delay;
    int          pcw_cnt, cons_cnt, fl_cnt;

    logic        o_pcw, o_rv, o_valid, o_fault, o_hs, o_rsp;
    logic [31:0] o_addr, o_ipc, o_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample at mid-cycle, check spec rules, then advance PC and memory models.
    task automatic cycle(input bit fl, input logic [31:0] tgt, input bit dr, input bit rdy);
        logic [31:0] nxt;
        @(negedge CPU_clk);
        flush              = fl;
        decode_ready       = dr;
        bus.imem_req_ready = rdy;
        o_rsp              = pend && (cnt == 0);
        bus.imem_rsp_valid = o_rsp;
        bus.imem_rsp_data  = o_rsp ? memf(paddr) : $urandom;
        #1;
        o_pcw   = PCWrite;
        o_rv    = bus.imem_req_valid;
        o_addr  = bus.imem_req_addr;
        o_valid = Instr_valid;
        o_ipc   = Instr_PC;
        o_instr = Instr;
        o_fault = fetch_fault;
        o_hs    = o_rv && rdy;
        chk("pcwrite", o_pcw, boot || fl || (o_valid && dr));
        if (o_valid) begin
            chk("instr_pc", o_ipc, exp_addr);
            chk("instr_data", o_instr, memf(o_ipc));
        end
        if (o_rv) begin
            chk("req_addr", o_addr, pc_m);
            chk("req_aligned", o_addr[1:0], 0);
            chk("req_single", pend, 0);
        end
        nxt = fl ? tgt : pc_m + 32'd4;
        if (fl) begin
            exp_addr = tgt;
            fl_cnt++;
        end else if (o_valid && dr) begin
            exp_addr = exp_addr + 32'd4;
            cons_cnt++;
        end
        if (o_pcw) pcw_cnt++;
        boot = 1'b0;
        @(posedge CPU_clk);
        #1;
        if (o_pcw) pc_m = nxt;
        PC = pc_m;
        if (o_rsp) pend = 1'b0;
        else if (pend && cnt > 0) cnt--;
        if (o_hs) begin
            pend  = 1'b1;
            paddr = o_addr;
            cnt   = rsp_delay;
        end
    endtask

    task automatic do_reset();
        CPU_rst_n          = 1'b0;
        flush              = 1'b0;
        decode_ready       = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        pc_m      = RESET_PC_DEF;
        PC        = pc_m;
        pend      = 1'b0;
        cnt       = 0;
        rsp_delay = 0;
        exp_addr  = 32'h0;
        boot      = 1'b1;
        pcw_cnt   = 0;
        cons_cnt  = 0;
        fl_cnt    = 0;
        repeat (2) @(negedge CPU_clk);
        #1;
        chk("rst_pcwrite", PCWrite, 1);
        chk("rst_valid", Instr_valid, 0);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_instr_pc", Instr_PC, 0);
        @(posedge CPU_clk);
        #1;
        CPU_rst_n = 1'b1;
    endtask

    initial begin
        bit seen;

        // Boot and streaming: memory always ready, 1-cycle response, decode always ready
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, 1);
            if (i == 0) chk("boot_no_req", o_rv, 0);
            if (i == 1) begin
                chk("first_req_valid", o_rv, 1);
                chk("first_req_addr", o_addr, 32'h0);
            end
            if (i == 3 || i == 6 || i == 9) begin
                chk("stream_valid", o_valid, 1);
                chk("stream_pc", o_ipc, (i / 3 - 1) * 4);
            end
        end

        // Memory not ready for 4 cycles at PC 0x10
        for (int i = 0; i < 40 && pc_m != 32'h10; i++) cycle(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0);
            chk("stall_req_valid", o_rv, 1);
            chk("stall_req_addr", o_addr, 32'h10);
            chk("stall_pcwrite", o_pcw, 0);
        end
        cycle(0, 0, 1, 1);
        chk("stall_handshake", o_hs, 1);

        // Decode back-pressure for 5 cycles in HOLD
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 1);
            chk("hold_valid", o_valid, 1);
            chk("hold_pc", o_ipc, 32'h10);
            chk("hold_instr", o_instr, memf(32'h10));
            chk("hold_pcwrite", o_pcw, 0);
        end
        cycle(0, 0, 1, 1);
        chk("hold_release_pcwrite", o_pcw, 1);
        cycle(0, 0, 1, 1);
        chk("hold_next_addr", o_addr, 32'h14);

        // Flush in WAIT for 0x20 before the response arrives
        for (int i = 0; i < 40 && pc_m != 32'h20; i++) cycle(0, 0, 1, 1);
        rsp_delay = 1;
        cycle(0, 0, 1, 1);
        chk("req_20_handshake", o_hs, 1);
        chk("req_20_addr", o_addr, 32'h20);
        rsp_delay = 0;
        cycle(1, 32'h100, 1, 1);
        chk("flush_wait_pcwrite", o_pcw, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 1);
            if (o_hs && !seen) begin
                chk("redirect_addr", o_addr, 32'h100);
                seen = 1'b1;
            end
        end
        chk("redirect_seen", seen, 1);

        // Flush coinciding with the response in WAIT
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 1, 1);
            if (o_hs) break;
        end
        cycle(1, 32'h300, 1, 1);
        chk("flush_rsp_pcwrite", o_pcw, 1);
        cycle(0, 0, 1, 0);
        chk("flush_rsp_no_valid", o_valid, 0);
        chk("flush_rsp_single_pcwrite", o_pcw, 0);
        chk("flush_rsp_next_addr", o_addr, 32'h300);

        // Flush in HOLD while decode is also ready
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 32'h400, 1, 1);
        chk("flush_hold_valid", o_valid, 1);
        chk("flush_hold_pcwrite", o_pcw, 1);
        cycle(0, 0, 0, 0);
        chk("flush_hold_no_valid", o_valid, 0);
        chk("flush_hold_single_pcwrite", o_pcw, 0);
        chk("flush_hold_next_addr", o_addr, 32'h400);

        // Misaligned PC: sticky fault cleared by a flush
        cycle(1, 32'h102, 0, 0);
        cycle(0, 0, 0, 0);
        chk("misaligned_no_req", o_rv, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1);
            chk("fault_set", o_fault, 1);
            chk("fault_no_req", o_rv, 0);
            chk("fault_pcwrite", o_pcw, 0);
        end
        cycle(1, 32'h200, 0, 1);
        chk("fault_flush_pcwrite", o_pcw, 1);
        cycle(0, 0, 0, 1);
        chk("fault_cleared", o_fault, 0);
        chk("fault_exit_req", o_rv, 1);
        chk("fault_exit_addr", o_addr, 32'h200);

        // Randomized traffic against the PC/memory/decode models
        for (int i = 0; i < 400; i++) begin
            rsp_delay = $urandom_range(0, 2);
            cycle($urandom_range(0, 19) == 0, $urandom & 32'h0000_FFFC,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
        end
        chk("pcwrite_count", pcw_cnt, 1 + cons_cnt + fl_cnt);
        chk("random_progress", cons_cnt > 10, 1);

        // Reset in the middle of a transaction
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 1, 1);
            if (o_hs) break;
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 1);
            if (i == 1) chk("rereset_first_addr", o_addr, 32'h0);
            if (i == 3) begin
                chk("rereset_valid", o_valid, 1);
                chk("rereset_pc", o_ipc, 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
